// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and the load/store
//   unit (DM). Exactly one transaction is in flight. The FSM steps through
//   IDLE -> REQ -> RESP. The mem_* request fields are registered, so they stay
//   stable while the transaction waits for mem_gnt.
//
//   Build option: MEM_PORT_ARB_RR_EN
//     Undefined (default): fixed priority. DM wins a tie.
//     Defined: round-robin. A tie goes to the requester that did not win the
//     previous grant. The first tie after reset goes to DM.
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     if_req/if_addr                fetch request (held until if_gnt)
//     if_gnt/if_rvalid/if_rdata     fetch accept pulse, data valid pulse, data
//     dm_req/we/be/addr/wdata       LSU request (held until dm_gnt)
//     dm_gnt/dm_rvalid/dm_rdata     LSU accept pulse, load data / store done, data
//     mem_req/we/be/addr/wdata      registered memory request
//     mem_gnt/mem_rvalid/mem_rdata  memory accept, response valid, read data
//     busy                          FSM not in IDLE
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    output logic                    dm_gnt,
    output logic                    dm_rvalid,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    localparam int BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;      // 1 = DM owns the transaction
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [BE_W-1:0]         mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    pick_dm;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_dm_q, last_dm_d;                     // 1 = DM won the last grant
    // On a tie, give the grant to whichever requester did not win last.
    assign pick_dm = dm_req && (!if_req || !last_dm_q);
`else
    assign pick_dm = dm_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_PORT_ARB_RR_EN
        last_dm_d   = last_dm_q;
`endif
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        dm_rvalid   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_d   = REQ;
                    owner_d   = pick_dm;
                    mem_req_d = 1'b1;
`ifdef MEM_PORT_ARB_RR_EN
                    last_dm_d = pick_dm;
`endif
                    // The grant is combinational. It is gated by rst_n so
                    // that no grant is seen while reset is held.
                    if (pick_dm) begin
                        dm_gnt      = rst_n;
                        mem_we_d    = dm_we;
                        mem_be_d    = dm_be;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        if_gnt      = rst_n;
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    if_rvalid = !owner_q;
                    dm_rvalid = owner_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_PORT_ARB_RR_EN
            last_dm_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_dm_q   <= last_dm_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Inputs are driven 1 ns after each rising edge. Outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, busy;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    // Checks that the memory side of the DUT is fully idle.
    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_req"},   {31'd0, mem_req},   32'd0);
        chk({tag, ".busy"},      {31'd0, busy},      32'd0);
        chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        chk({tag, ".dm_rvalid"}, {31'd0, dm_rvalid}, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_dm;
        rst_n = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0; dm_be = 0;
        #2;
        chk_quiet("rst");
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.if_gnt", {31'd0, if_gnt}, 32'd0);
        tick; tick; rst_n = 1'b1;

        // Single fetch. mem_gnt is already high in IDLE, where it must be ignored.
        tick; if_req = 1; if_addr = 32'h40; mem_gnt = 1;
        samp; chk("f.if_gnt", {31'd0, if_gnt}, 32'd1);
              chk("f.dm_gnt", {31'd0, dm_gnt}, 32'd0);
              chk("f.busy0",  {31'd0, busy},   32'd0);
        tick; if_req = 0; if_addr = 32'hFFFF;
        samp; chk("f.mem_req", {31'd0, mem_req}, 32'd1);
              chk("f.mem_addr", mem_addr, 32'h40);
              chk("f.mem_we", {31'd0, mem_we}, 32'd0);
              chk("f.mem_be", {28'd0, mem_be}, 32'hF);
              chk("f.mem_wdata", mem_wdata, 32'd0);
              chk("f.if_gnt1", {31'd0, if_gnt}, 32'd0);
        tick; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13;
        samp; chk("f.if_rvalid", {31'd0, if_rvalid}, 32'd1);
              chk("f.if_rdata", if_rdata, 32'h13);
              chk("f.dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
              chk("f.mem_req2", {31'd0, mem_req}, 32'd0);
        tick; mem_rvalid = 0;
        samp; chk_quiet("f.end");

        // Store with mem_gnt delayed 3 cycles. Request inputs and rvalid change while in REQ.
        tick; dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        samp; chk("s.dm_gnt", {31'd0, dm_gnt}, 32'd1);
              chk("s.if_gnt", {31'd0, if_gnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick; dm_req = 0; dm_addr = 32'h999; dm_wdata = 32'h1234; mem_rvalid = (i == 1);
            mem_gnt = (i == 3);
            samp; chk("s.mem_req", {31'd0, mem_req}, 32'd1);
                  chk("s.mem_addr", mem_addr, 32'h100);
                  chk("s.mem_wdata", mem_wdata, 32'hDEADBEEF);
                  chk("s.mem_be", {28'd0, mem_be}, 32'h3);
                  chk("s.mem_we", {31'd0, mem_we}, 32'd1);
                  chk("s.rv_in_req", {31'd0, dm_rvalid}, 32'd0);
        end
        // In RESP, mem_gnt is noise and there is no rvalid yet.
        tick; mem_gnt = 1; mem_rvalid = 0;
        samp; chk("s.resp_mem_req", {31'd0, mem_req}, 32'd0);
              chk("s.resp_busy", {31'd0, busy}, 32'd1);
              chk("s.resp_norv", {31'd0, dm_rvalid}, 32'd0);
        tick; mem_gnt = 0; mem_rvalid = 1;
        samp; chk("s.dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
              chk("s.if_rvalid", {31'd0, if_rvalid}, 32'd0);
        // Back in IDLE. A stray rvalid here must be ignored.
        tick;
        samp; chk_quiet("s.idle_noise");

        // Reset while in RESP. The pending response is dropped.
        tick; mem_rvalid = 0; if_req = 1; if_addr = 32'h80;
        tick; if_req = 0; mem_gnt = 1;
        tick; mem_gnt = 0;
        samp; chk("r.in_resp", {31'd0, busy}, 32'd1);
        #2; rst_n = 0; if_req = 1; mem_rvalid = 1;
        #1; chk_quiet("r.during");
            chk("r.if_gnt", {31'd0, if_gnt}, 32'd0);
        tick; rst_n = 1; if_req = 0;
        samp; chk_quiet("r.after");

        // Both requesters high on every cycle, with a zero-wait memory.
        tick; mem_rvalid = 1; mem_gnt = 1; mem_rdata = 32'h55;
        if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h300;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_PORT_ARB_RR_EN
            exp_dm = (t % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            samp; chk("c.dm_gnt", {31'd0, dm_gnt}, {31'd0, exp_dm});
                  chk("c.if_gnt", {31'd0, if_gnt}, {31'd0, !exp_dm});
            tick;
            samp; chk("c.gnt_pulse", {30'd0, if_gnt, dm_gnt}, 32'd0);
                  chk("c.mem_addr", mem_addr, exp_dm ? 32'h300 : 32'h200);
            tick;
            samp; chk("c.dm_rvalid", {31'd0, dm_rvalid}, {31'd0, exp_dm});
                  chk("c.if_rvalid", {31'd0, if_rvalid}, {31'd0, !exp_dm});
            tick;
        end
        if_req = 0; dm_req = 0; mem_gnt = 0; mem_rvalid = 0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares a single memory port between instruction fetch (IF) and the load/store unit (DM) in the single-port-memory RV32I core configuration. Accepts one request per transaction, latches its fields, and drives a registered req/gnt/rvalid transaction on the memory port. Routes the response back to whichever requester owns the transaction. Sits between the fetch stage, the LSU and the memory wrapper.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width = DATA_WIDTH/8

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_WIDTH  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  DATA_WIDTH  fetch data
dm_req  in  1  data request; held with fields until dm_gnt
dm_we  in  1  1=store, 0=load
dm_be  in  DATA_WIDTH/8  byte enables
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_gnt  out  1  data request accepted (1-cycle pulse)
dm_rvalid  out  1  load data / store completion (1-cycle pulse)
dm_rdata  out  DATA_WIDTH  load data
mem_req  out  1  memory request, registered
mem_we  out  1  registered
mem_be  out  DATA_WIDTH/8  registered
mem_addr  out  ADDR_WIDTH  registered
mem_wdata  out  DATA_WIDTH  registered
mem_gnt  in  1  memory accepted mem_req this cycle
mem_rvalid  in  1  memory response valid
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  high in any state except IDLE

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). While rst_n=0: state=IDLE, owner=IF; all mem_* registers, if_gnt, dm_gnt, if_rvalid, dm_rvalid and busy are 0.
- FSM states: IDLE, REQ, RESP. Exactly one outstanding transaction.
- IDLE: if any req is high, select a winner. Assert winner's gnt combinationally in that cycle. At the clock edge, latch owner and fields into the mem_* registers, set mem_req=1, and go to REQ.
  - Fetch transactions drive mem_we=0, mem_be=all ones, mem_wdata=0.
- Arbitration: fixed priority, DM wins over IF when both request.
- REQ: hold mem_req and fields stable. When mem_gnt=1, go to RESP and clear mem_req at that edge.
- RESP: when mem_rvalid=1, pulse the owner's rvalid that cycle (combinational from mem_rvalid) and go to IDLE.
  - if_rdata and dm_rdata both carry mem_rdata unconditionally. Only the owner's rvalid qualifies it.
  - Stores also complete with dm_rvalid; the rdata value is don't-care.
- Minimum occupancy: 3 cycles per transaction (IDLE, REQ, RESP) with zero-wait memory. A new grant is possible in the cycle after rvalid.
- mem_rvalid outside RESP is ignored. mem_gnt outside REQ is ignored.
- A requester may drop req before its gnt with no effect. Deasserting req after gnt does not cancel the transaction.
- Inputs sampled only in IDLE. Changes to addr/data during REQ/RESP do not affect mem_*.
- Reset mid-transaction: returns to IDLE immediately and clears mem_req. The pending response is dropped; no rvalid is generated.

Optional Feature:
MEM_PORT_ARB_RR_EN
- Defined: round-robin arbitration. A last-winner register (reset value = IF) is updated at each grant. On a tie, the requester that did not win last is granted, so the first tie after reset goes to DM.
- Undefined: fixed DM priority as above; no last-winner register.

Test Plan:
- Reset mid-op: assert rst_n=0 while in RESP, then release and send mem_rvalid=1 -> no rvalid pulse; all outputs 0; state IDLE.
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_gnt=1 on first REQ cycle, mem_rvalid=1 with mem_rdata=0x0000_0013 next cycle -> if_gnt pulse cycle 0; mem_req=1, mem_addr=0x40, mem_we=0, mem_be=4'hF in cycle 1; if_rvalid=1 with if_rdata=0x13 in cycle 2; dm_rvalid stays 0.
- Store: dm_req=1, dm_we=1, dm_be=4'b0011, dm_addr=0x100, dm_wdata=0xDEADBEEF; mem_gnt delayed 3 cycles -> mem_req held 4 cycles with fields stable; one dm_rvalid pulse on mem_rvalid.
- Collision, macro undefined: if_req and dm_req both high every cycle -> grants go DM, DM, DM…; IF starves; if_gnt is never asserted while dm_req=1.
- Collision, MEM_PORT_ARB_RR_EN defined: same stimulus -> grants alternate DM, IF, DM, IF; each gnt is a single-cycle pulse.
- Protocol noise: mem_rvalid=1 pulsed while in IDLE and REQ, and mem_gnt=1 in RESP -> no rvalid pulses and no state change until the legal events arrive.
